// File: rtl/dsi_payload_crc_append_pkg.sv
// ---------------------------------------------------------------------------
// dsi_pkg: shared DSI checksum constants and CRC-append FSM encoding. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dsi_pkg;

  localparam logic [15:0] DSI_CRC_SEED = 16'hFFFF;
  localparam logic [15:0] DSI_CRC_POLY = 16'h8408;

  localparam logic [1:0] S_PAYLOAD = 2'd0;
  localparam logic [1:0] S_CRC_LO  = 2'd1;
  localparam logic [1:0] S_CRC_HI  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/dsi_payload_crc_append_crc_step.sv
// ---------------------------------------------------------------------------
// dsi_payload_crc_append_crc_step: one-byte reflected CRC-16 (0x8408) step. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dsi_payload_crc_append_crc_step
  import dsi_pkg::*;
(
  input  logic [15:0] crc,
  input  logic [7:0]  data,
  output logic [15:0] crc_next
);

  logic [15:0] acc;

  // Byte is folded in first, then shifted out LSB first.
  always_comb begin
    acc = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      acc = acc[0] ? ((acc >> 1) ^ DSI_CRC_POLY) : (acc >> 1);
    end
    crc_next = acc;
  end

endmodule

`default_nettype wire

// File: rtl/dsi_payload_crc_append.sv
// ---------------------------------------------------------------------------
// dsi_payload_crc_append: passes payload bytes and appends the DSI CRC-16 footer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dsi_payload_crc_append
  import dsi_pkg::*;
#(
  parameter logic [15:0] CRC_SEED = DSI_CRC_SEED
)
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] d_data_i,
  input  logic       d_valid_i,
  input  logic       d_last_i,
  output logic       d_ready_o,
  input  logic       empty_req_i,
  output logic [7:0] q_data_o,
  output logic       q_valid_o,
  output logic       q_last_o,
  input  logic       q_ready_i,
  output logic       busy_o
);

  logic [1:0]  state;
  logic [15:0] crc;
  logic [15:0] crc_next;
  logic        in_pkt;
  logic        slot;
  logic        accept;
  logic        empty_go;

  assign slot      = !q_valid_o || q_ready_i;
  assign d_ready_o = rst_n_i && slot && (state == S_PAYLOAD);
  assign accept    = d_valid_i && d_ready_o;
  // A payload byte in the same cycle takes priority over the empty request.
  assign empty_go  = (state == S_PAYLOAD) && !in_pkt && empty_req_i && slot && !d_valid_i;
  // Still busy while the CRC high byte waits in the output register.
  assign busy_o    = in_pkt || (q_valid_o && q_last_o);

  dsi_payload_crc_append_crc_step u_crc_step (
    .crc      (crc),
    .data     (d_data_i),
    .crc_next (crc_next)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= S_PAYLOAD;
      crc       <= CRC_SEED;
      in_pkt    <= 1'b0;
      q_valid_o <= 1'b0;
      q_data_o  <= 8'h00;
      q_last_o  <= 1'b0;
    end else begin
      if (q_valid_o && q_ready_i) begin
        q_valid_o <= 1'b0;
      end
      case (state)
        S_PAYLOAD: begin
          if (accept) begin
            q_data_o  <= d_data_i;
            q_valid_o <= 1'b1;
            q_last_o  <= 1'b0;
            crc       <= crc_next;
            in_pkt    <= 1'b1;
            if (d_last_i) begin
              state <= S_CRC_LO;
            end
          end else if (empty_go) begin
            in_pkt <= 1'b1;
            state  <= S_CRC_LO;
          end
        end
        S_CRC_LO: begin
          if (slot) begin
            q_data_o  <= crc[7:0];
            q_valid_o <= 1'b1;
            q_last_o  <= 1'b0;
            state     <= S_CRC_HI;
          end
        end
        S_CRC_HI: begin
          if (slot) begin
            q_data_o  <= crc[15:8];
            q_valid_o <= 1'b1;
            q_last_o  <= 1'b1;
            crc       <= CRC_SEED;
            in_pkt    <= 1'b0;
            state     <= S_PAYLOAD;
          end
        end
        default: begin
          state <= S_PAYLOAD;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dsi_payload_crc_append.sv
// ---------------------------------------------------------------------------
// tb_dsi_payload_crc_append: directed checks of payload pass-through and CRC footer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dsi_payload_crc_append;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic [7:0] d_data_i = 8'h00;
  logic       d_valid_i = 1'b0;
  logic       d_last_i = 1'b0;
  logic       d_ready_o;
  logic       empty_req_i = 1'b0;
  logic [7:0] q_data_o;
  logic       q_valid_o;
  logic       q_last_o;
  logic       q_ready_i = 1'b1;
  logic       busy_o;

  dsi_payload_crc_append dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .d_data_i    (d_data_i),
    .d_valid_i   (d_valid_i),
    .d_last_i    (d_last_i),
    .d_ready_o   (d_ready_o),
    .empty_req_i (empty_req_i),
    .q_data_o    (q_data_o),
    .q_valid_o   (q_valid_o),
    .q_last_o    (q_last_o),
    .q_ready_i   (q_ready_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int stall_err = 0;
  int dready_err = 0;
  int stall_seen = 0;
  bit rand_mode = 1'b0;

  logic [7:0] got_data[$];
  logic       got_last[$];
  int         got_cyc[$];
  logic [7:0] exp_data[$];
  logic       exp_last[$];

  logic [7:0] ascii[$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  initial forever begin
    @(posedge clk_i);
    #1;
    if (rand_mode) q_ready_i = 1'($urandom_range(0, 1));
  end

  // Output monitor: records transfers and tracks hold-stability during stalls.
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;
  logic       stall_last = 1'b0;
  initial forever begin
    @(negedge clk_i);
    if (rst_n_i) begin
      if (stall_prev && !(q_valid_o === 1'b1 && q_data_o === stall_data && q_last_o === stall_last))
        stall_err++;
      if (q_valid_o && !q_ready_i) begin
        stall_seen++;
        if (d_ready_o !== 1'b0) dready_err++;
      end
      stall_prev = q_valid_o && !q_ready_i;
      stall_data = q_data_o;
      stall_last = q_last_o;
      if (q_valid_o && q_ready_i) begin
        got_data.push_back(q_data_o);
        got_last.push_back(q_last_o);
        got_cyc.push_back(cyc);
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  function automatic logic [15:0] ref_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ b[i];
      r  = r >> 1;
      if (fb) r = r ^ 16'h8408;
    end
    return r;
  endfunction

  task automatic add_pkt(input logic [7:0] pkt[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (pkt[i]) begin
      exp_data.push_back(pkt[i]);
      exp_last.push_back(1'b0);
      c = ref_step(c, pkt[i]);
    end
    exp_data.push_back(c[7:0]);
    exp_last.push_back(1'b0);
    exp_data.push_back(c[15:8]);
    exp_last.push_back(1'b1);
  endtask

  task automatic add_byte(input logic [7:0] d, input logic l);
    exp_data.push_back(d);
    exp_last.push_back(l);
  endtask

  task automatic clear_q();
    got_data.delete();
    got_last.delete();
    got_cyc.delete();
    exp_data.delete();
    exp_last.delete();
  endtask

  // Stimulus helpers run from posedge+1 and return at posedge+1 after the accept.
  task automatic send_byte(input logic [7:0] d, input logic l);
    bit acc;
    int k;
    d_valid_i = 1'b1;
    d_data_i  = d;
    d_last_i  = l;
    k = 0;
    do begin
      @(negedge clk_i);
      acc = d_ready_o;
      @(posedge clk_i);
      #1;
      k++;
    end while (!acc && k < 500);
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: byte %h not accepted within %0d cycles (need accept)", d, k);
    end
  endtask

  task automatic send_pkt(input logic [7:0] pkt[$]);
    foreach (pkt[i]) send_byte(pkt[i], i == pkt.size() - 1);
  endtask

  task automatic idle();
    d_valid_i = 1'b0;
    d_last_i  = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int k;
    k = 0;
    while (got_data.size() < n && k < 600) begin
      @(posedge clk_i);
      k++;
    end
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    n_cmp++; if (q_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_q_valid: got %b need 0", q_valid_o); end
    n_cmp++; if (q_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_q_data: got %h need 00", q_data_o); end
    n_cmp++; if (q_last_o !== 1'b0) begin n_fail++; $display("FAIL reset_q_last: got %b need 0", q_last_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b need 0", busy_o); end
    n_cmp++; if (d_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_d_ready: got %b need 0", d_ready_o); end
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
  endtask

  task automatic test_ascii();
    logic [7:0] hc[$];
    clear_q();
    hc = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h91, 8'h6F};
    foreach (hc[i]) add_byte(hc[i], i == 10);
    send_byte(8'h31, 1'b0);
    n_cmp++; if (q_valid_o !== 1'b1 || q_data_o !== 8'h31) begin n_fail++; $display("FAIL ascii_latency: got valid=%b data=%h need valid=1 data=31", q_valid_o, q_data_o); end
    n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL ascii_busy: got %b need 1", busy_o); end
    for (int i = 1; i < 9; i++) send_byte(ascii[i], i == 8);
    idle();
    wait_out(11);
    n_cmp++; if (got_data.size() !== 11) begin n_fail++; $display("FAIL ascii_count: got %0d bytes need 11", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      n_cmp++;
      if ({got_last[i], got_data[i]} !== {exp_last[i], exp_data[i]}) begin
        n_fail++;
        $display("FAIL ascii_byte%0d: got last=%b data=%h need last=%b data=%h", i, got_last[i], got_data[i], exp_last[i], exp_data[i]);
      end
    end
    if (got_cyc.size() == 11) begin
      n_cmp++; if (got_cyc[10] - got_cyc[0] !== 10) begin n_fail++; $display("FAIL ascii_span: got %0d cycles need 10", got_cyc[10] - got_cyc[0]); end
    end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL ascii_idle_busy: got %b need 0", busy_o); end
  endtask

  task automatic test_empty();
    clear_q();
    add_byte(8'hFF, 1'b0);
    add_byte(8'hFF, 1'b1);
    add_byte(8'h00, 1'b0);
    add_byte(8'h87, 1'b0);
    add_byte(8'h0F, 1'b1);
    empty_req_i = 1'b1;
    @(posedge clk_i);
    #1;
    empty_req_i = 1'b0;
    n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL empty_busy: got %b need 1", busy_o); end
    wait_out(2);
    send_byte(8'h00, 1'b1);
    idle();
    wait_out(5);
    n_cmp++; if (got_data.size() !== 5) begin n_fail++; $display("FAIL empty_count: got %0d bytes need 5", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      n_cmp++;
      if ({got_last[i], got_data[i]} !== {exp_last[i], exp_data[i]}) begin
        n_fail++;
        $display("FAIL empty_byte%0d: got last=%b data=%h need last=%b data=%h", i, got_last[i], got_data[i], exp_last[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_single_repeat();
    clear_q();
    for (int p = 0; p < 2; p++) begin
      add_byte(8'h00, 1'b0);
      add_byte(8'h87, 1'b0);
      add_byte(8'h0F, 1'b1);
    end
    send_byte(8'h00, 1'b1);
    idle();
    repeat (4) @(posedge clk_i);
    #1;
    send_byte(8'h00, 1'b1);
    idle();
    wait_out(6);
    n_cmp++; if (got_data.size() !== 6) begin n_fail++; $display("FAIL single_count: got %0d bytes need 6", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      n_cmp++;
      if ({got_last[i], got_data[i]} !== {exp_last[i], exp_data[i]}) begin
        n_fail++;
        $display("FAIL single_byte%0d: got last=%b data=%h need last=%b data=%h", i, got_last[i], got_data[i], exp_last[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_q();
    add_pkt(ascii);
    stall_err  = 0;
    dready_err = 0;
    stall_seen = 0;
    rand_mode  = 1'b1;
    send_pkt(ascii);
    idle();
    wait_out(11);
    rand_mode = 1'b0;
    q_ready_i = 1'b1;
    n_cmp++; if (got_data.size() !== 11) begin n_fail++; $display("FAIL bp_count: got %0d bytes need 11", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      n_cmp++;
      if ({got_last[i], got_data[i]} !== {exp_last[i], exp_data[i]}) begin
        n_fail++;
        $display("FAIL bp_byte%0d: got last=%b data=%h need last=%b data=%h", i, got_last[i], got_data[i], exp_last[i], exp_data[i]);
      end
    end
    n_cmp++; if (stall_err !== 0) begin n_fail++; $display("FAIL bp_hold_stable: got %0d unstable stalls need 0", stall_err); end
    n_cmp++; if (dready_err !== 0) begin n_fail++; $display("FAIL bp_d_ready: got %0d stalls with d_ready high need 0", dready_err); end
    n_cmp++; if (stall_seen == 0) begin n_fail++; $display("FAIL bp_coverage: got %0d stall cycles need >0", stall_seen); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pa[$];
    logic [7:0] pb[$];
    clear_q();
    pa = '{8'hA5, 8'h5A, 8'hFF};
    pb = '{8'h12, 8'h34};
    add_pkt(pa);
    add_pkt(pb);
    send_pkt(pa);
    send_pkt(pb);
    idle();
    wait_out(9);
    n_cmp++; if (got_data.size() !== 9) begin n_fail++; $display("FAIL b2b_count: got %0d bytes need 9", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      n_cmp++;
      if ({got_last[i], got_data[i]} !== {exp_last[i], exp_data[i]}) begin
        n_fail++;
        $display("FAIL b2b_byte%0d: got last=%b data=%h need last=%b data=%h", i, got_last[i], got_data[i], exp_last[i], exp_data[i]);
      end
    end
    for (int i = 1; i < got_cyc.size(); i++) begin
      n_cmp++;
      if (got_cyc[i] !== got_cyc[i-1] + 1) begin
        n_fail++;
        $display("FAIL b2b_gap%0d: got cycle %0d need %0d", i, got_cyc[i], got_cyc[i-1] + 1);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] hc[$];
    clear_q();
    for (int i = 0; i < 4; i++) send_byte(ascii[i], 1'b0);
    idle();
    #1;
    rst_n_i = 1'b0;
    #1;
    n_cmp++; if (q_valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_q_valid: got %b need 0", q_valid_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b need 0", busy_o); end
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    clear_q();
    hc = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h91, 8'h6F};
    foreach (hc[i]) add_byte(hc[i], i == 10);
    send_pkt(ascii);
    idle();
    wait_out(11);
    n_cmp++; if (got_data.size() !== 11) begin n_fail++; $display("FAIL midrst_count: got %0d bytes need 11", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      n_cmp++;
      if ({got_last[i], got_data[i]} !== {exp_last[i], exp_data[i]}) begin
        n_fail++;
        $display("FAIL midrst_byte%0d: got last=%b data=%h need last=%b data=%h", i, got_last[i], got_data[i], exp_last[i], exp_data[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ascii();
    test_empty();
    test_single_repeat();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dsi_payload_crc_append.md
Name: dsi_payload_crc_append

Overview:
- Sits between the long-packet payload source (pixel packer / host FIFO) and the lane serializer.
- Passes payload bytes through one registered output stage and accumulates the DSI CRC-16 checksum over them.
- Appends the 2-byte checksum footer (LSB first) after the last payload byte.
- Also generates the footer-only sequence (0xFF, 0xFF) for zero-length long packets.

Parameters:
- CRC_SEED, 16'hFFFF, checksum preset loaded at packet start.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- d_data_i  in  8  payload byte
- d_valid_i  in  1  payload byte valid
- d_last_i  in  1  marks final payload byte of packet
- d_ready_o  out  1  block accepts payload byte this cycle
- empty_req_i  in  1  request footer for zero-length packet (sampled only in S_PAYLOAD with no packet in progress)
- q_data_o  out  8  output byte
- q_valid_o  out  1  output byte valid
- q_last_o  out  1  marks CRC high byte (end of packet body)
- q_ready_i  in  1  downstream accepts output byte
- busy_o  out  1  packet in progress (first byte accepted, CRC high not yet transferred)

Behaviour:
- Reset (async, rst_n_i=0):
  - State S_PAYLOAD, crc=CRC_SEED, in_pkt=0.
  - q_valid_o=0, q_data_o=0, q_last_o=0, busy_o=0, d_ready_o=0 while in reset.
- CRC definition:
  - Polynomial x^16+x^12+x^5+1, reflected (0x8408 form), each byte processed LSB first, no final XOR.
  - One byte per cycle via a combinational step function crc_next=step(crc, byte).
- Handshakes:
  - Output transfer when q_valid_o&q_ready_i.
  - Input transfer when d_valid_i&d_ready_o.
  - Output register may load when !q_valid_o | q_ready_i (call it "slot").
  - d_ready_o = slot & (state==S_PAYLOAD) & !empty_req_i-path-pending. Purely combinational from state and q_ready_i, never from d_valid_i.
- S_PAYLOAD:
  - On input transfer: q_data_o<=d_data_i, q_valid_o<=1, q_last_o<=0, crc<=step(crc,d_data_i), in_pkt<=1.
  - If d_last_i: state<=S_CRC_LO.
  - Latency input to output: 1 cycle.
  - If !in_pkt & empty_req_i & slot & !d_valid_i: crc stays CRC_SEED, in_pkt<=1, state<=S_CRC_LO, no byte emitted. If d_valid_i and empty_req_i are both high, d_valid_i wins; empty_req_i is ignored that cycle.
- S_CRC_LO: when slot: q_data_o<=crc[7:0], q_valid_o<=1, q_last_o<=0, state<=S_CRC_HI.
- S_CRC_HI: when slot: q_data_o<=crc[15:8], q_valid_o<=1, q_last_o<=1, crc<=CRC_SEED, in_pkt<=0, state<=S_PAYLOAD.
- Back-pressure: q_data_o/q_last_o stable while q_valid_o&!q_ready_i; no byte dropped or duplicated.
- Full throughput: with q_ready_i=1, a packet of N payload bytes occupies the output for exactly N+2 consecutive cycles. The next packet's first byte may be accepted in the cycle the CRC high byte is loaded+1.
- busy_o = in_pkt | (q_valid_o & !last-transferred).
- Mid-packet reset: all state cleared, partial packet discarded; downstream sees q_valid_o drop asynchronously.
- q_valid_o drops to 0 after a transfer only when no new byte is loaded that cycle.

Decomposition:
- Shared package dsi_pkg:
  - DSI_CRC_SEED=16'hFFFF and DSI_CRC_POLY=16'h8408 constants.
  - State encoding localparams (S_PAYLOAD, S_CRC_LO, S_CRC_HI).
- One sub-module: the existing combinational CRC byte-step module, instantiated once on (crc, d_data_i).
- The FSM and output register stay in this module.

Test Plan:
- ASCII "123456789" (0x31..0x39, last on 0x39), q_ready_i=1 -> 11 bytes out: 0x31..0x39, 0x91, 0x6F; q_last_o only on 0x6F.
- empty_req_i pulse, no payload -> output 0xFF, 0xFF; q_last_o on second; crc reset to 0xFFFF afterwards.
- Single byte 0x00 with last -> 0x00, then the CRC bytes from the reference model. A repeat packet yields identical bytes, proving the seed reload.
- "123456789" with q_ready_i random 50% -> identical byte sequence to the first test; q_data_o stable during every stall; d_ready_o low whenever the output is held.
- Two back-to-back packets (3 bytes, then 2 bytes) with d_valid_i held high -> 9 output bytes with no gap cycles; each checksum is independent.
- rst_n_i asserted mid-payload after 4 bytes -> q_valid_o=0 immediately. A following "123456789" packet still ends 0x91, 0x6F.
